// File: rtl/mrelbp_ci_frame.sv
// MRELBP centre-intensity stage: pipelined 3x3 median, threshold compare, and a
// background restoring divider that turns each frame's median sum into the next threshold.
module mrelbp_ci_frame #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned IMG_W         = 64,
  parameter int unsigned IMG_H         = 64,
  parameter int unsigned USE_PREV_MEAN = 1,
  parameter int unsigned MEAN_INIT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] S1,
  input  logic [DATA_WIDTH-1:0] S2,
  input  logic [DATA_WIDTH-1:0] S3,
  input  logic [DATA_WIDTH-1:0] S4,
  input  logic [DATA_WIDTH-1:0] S5,
  input  logic [DATA_WIDTH-1:0] S6,
  input  logic [DATA_WIDTH-1:0] S7,
  input  logic [DATA_WIDTH-1:0] S8,
  input  logic [DATA_WIDTH-1:0] S9,
  input  logic [DATA_WIDTH-1:0] thr_i,
  output logic                  done_o,
  output logic                  ci_o,
  output logic                  progress_done_o,
  output logic [DATA_WIDTH-1:0] mean_o,
  output logic                  mean_valid_o,
  output logic                  overrun_o
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned PIXELS = IMG_W * IMG_H;
  localparam int unsigned CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int unsigned SUM_W  = DW + $clog2(PIXELS);
  localparam int unsigned REM_W  = CNT_W;
  localparam int unsigned SH_W   = REM_W + 1;
  localparam int unsigned BIT_W  = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, COMMIT = 2'd2} state_e;

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [DW-1:0] win [9];
  assign win = '{S1, S2, S3, S4, S5, S6, S7, S8, S9};

  state_e             state_q, state_d;
  logic               v1_q, v2_q, v3_q, done_q, ci_q, prog_q, mv_q, ovr_q;
  logic               ci_d, prog_d, mv_d, ovr_d;
  logic [DW-1:0]      lo_q [3], mid_q [3], hi_q [3];
  logic [DW-1:0]      lo_d [3], mid_d [3], hi_d [3];
  logic [DW-1:0]      a_q, b_q, c_q, med_q, mean_q;
  logic [DW-1:0]      a_d, b_d, c_d, med_d, mean_d, thr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d, dvd_q, dvd_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [SH_W-1:0]    rem_sh;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               frame_end, qbit;

  // Median network: row sort, then max-of-lows / median-of-mids / min-of-highs, then median.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      lo_d[r]  = min2(min2(win[3*r], win[3*r+1]), win[3*r+2]);
      hi_d[r]  = max2(max2(win[3*r], win[3*r+1]), win[3*r+2]);
      mid_d[r] = med3(win[3*r], win[3*r+1], win[3*r+2]);
    end
    a_d   = max2(max2(lo_q[0], lo_q[1]), lo_q[2]);
    b_d   = med3(mid_q[0], mid_q[1], mid_q[2]);
    c_d   = min2(min2(hi_q[0], hi_q[1]), hi_q[2]);
    med_d = med3(a_q, b_q, c_q);
    thr   = (USE_PREV_MEAN != 0) ? mean_q : thr_i;
    ci_d  = v3_q && (med_q >= thr);
  end

  // Frame accumulation and divider sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    bit_d     = bit_q;
    mean_d    = mean_q;
    mv_d      = 1'b0;
    prog_d    = 1'b0;
    ovr_d     = ovr_q;
    rem_sh    = '0;
    qbit      = 1'b0;
    frame_end = v3_q && (cnt_q == CNT_W'(PIXELS - 1));

    if (v3_q) begin
      if (frame_end) begin
        sum_d  = '0;
        cnt_d  = '0;
        prog_d = 1'b1;
      end else begin
        sum_d = sum_q + SUM_W'(med_q);
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (state_q != IDLE && (cnt_q == '0 || frame_end)) ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_end) begin
          state_d = DIV;
          dvd_d   = sum_q + SUM_W'(med_q);
          rem_d   = '0;
          bit_d   = '0;
        end
      end
      DIV: begin
        rem_sh = {rem_q, dvd_q[SUM_W-1]};
        qbit   = (rem_sh >= SH_W'(PIXELS));
        rem_d  = qbit ? REM_W'(rem_sh - SH_W'(PIXELS)) : REM_W'(rem_sh);
        dvd_d  = {dvd_q[SUM_W-2:0], qbit};
        bit_d  = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(SUM_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        mean_d  = dvd_q[DW-1:0];
        mv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      done_q <= 1'b0; ci_q <= 1'b0; prog_q <= 1'b0; mv_q <= 1'b0; ovr_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        lo_q[r] <= '0; mid_q[r] <= '0; hi_q[r] <= '0;
      end
      a_q <= '0; b_q <= '0; c_q <= '0; med_q <= '0;
      mean_q <= DW'(MEAN_INIT);
      cnt_q <= '0; sum_q <= '0; dvd_q <= '0; rem_q <= '0; bit_q <= '0;
    end else begin
      v1_q <= done_i; v2_q <= v1_q; v3_q <= v2_q; done_q <= v3_q;
      lo_q <= lo_d; mid_q <= mid_d; hi_q <= hi_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; med_q <= med_d;
      ci_q <= ci_d; prog_q <= prog_d; mv_q <= mv_d; ovr_q <= ovr_d;
      mean_q <= mean_d;
      cnt_q <= cnt_d; sum_q <= sum_d; dvd_q <= dvd_d; rem_q <= rem_d; bit_q <= bit_d;
    end
  end

  assign done_o          = done_q;
  assign ci_o            = ci_q;
  assign progress_done_o = prog_q;
  assign mean_o          = mean_q;
  assign mean_valid_o    = mv_q;
  assign overrun_o       = ovr_q;

endmodule

// File: doc/mrelbp_ci_frame.md
Name: mrelbp_ci_frame

Overview:
Parametrised MRELBP centre-intensity (CI) stage for the streaming descriptor pipeline, successor to the fixed R4 CI block. It takes one 3x3 window per valid cycle and median-filters it through a pipelined 9-input median. It emits ci_o = (median >= threshold), where the threshold is either the mean of the previous frame's filtered image or an external value. The frame mean is produced in the background by a sequential restoring divider at each end of frame.

Parameters:
DATA_WIDTH, 8, sample width of S1..S9, mean_o and thr_i.
IMG_W, 64, pixels per line in the filtered image.
IMG_H, 64, lines per frame; PIXELS = IMG_W*IMG_H.
USE_PREV_MEAN, 1, 1 = threshold is the previous-frame mean; 0 = threshold is thr_i.
MEAN_INIT, 0, mean register value after reset; used as the threshold for the first frame.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-low reset.
done_i  in  1  window valid; S1..S9 are sampled when high.
S1..S9  in  DATA_WIDTH each  3x3 window, row-major, S5 = centre.
thr_i  in  DATA_WIDTH  external threshold; sampled at stage 4 when USE_PREV_MEAN=0.
done_o  out  1  ci_o valid.
ci_o  out  1  CI bit.
progress_done_o  out  1  one-cycle pulse on the done_o of the last pixel of a frame.
mean_o  out  DATA_WIDTH  committed frame mean.
mean_valid_o  out  1  one-cycle pulse when mean_o updates.
overrun_o  out  1  sticky flag: frame started while the divider was busy.

Behaviour:
- Reset (rst=0, asynchronous): pipeline valids, done_o, ci_o, progress_done_o, mean_valid_o, overrun_o = 0; pixel counter, sum and divider state cleared; mean_o = MEAN_INIT. Reset mid-frame discards the partial frame.
- Median pipeline, one register stage each, fully pipelined at 1 window per cycle, no backpressure:
  - S1: sort each row ascending into (lo, mid, hi).
  - S2: A = max of the row lows, B = median of the row mids, C = min of the row highs.
  - S3: med = median(A, B, C).
  - S4: ci_o = (med >= thr), compared unsigned; done_o = 1.
- Latency is exactly 4 cycles from done_i to done_o. Gaps in done_i propagate as gaps in done_o.
- Threshold: thr = mean_o if USE_PREV_MEAN=1, else thr_i.
- Accumulation:
  - Each stage-3 valid adds med into sum. sum width SUM_W = DATA_WIDTH + clog2(PIXELS); no overflow is possible.
  - The pixel counter wraps 0..PIXELS-1.
  - On count PIXELS-1: progress_done_o pulses with that pixel's done_o. The final sum is latched into the divider. sum and count clear for the next frame.
- Divider FSM:
  - States IDLE, DIV, COMMIT.
  - IDLE -> DIV on frame end.
  - DIV: restoring divide of the latched sum by constant PIXELS, one quotient bit per cycle, SUM_W cycles.
  - COMMIT: mean_o <= quotient (floor, fits DATA_WIDTH); mean_valid_o = 1 for 1 cycle; -> IDLE.
  - mean_valid_o therefore rises SUM_W+1 cycles after the cycle the final stage-3 sample is accumulated.
- Frame gap rule: upstream keeps at least SUM_W+2 idle cycles between the last window of a frame and the first of the next.
  - Violation: overrun_o sets (sticky until reset). Pixels reaching stage 4 before COMMIT use the old mean_o. Accumulation of the new frame proceeds unaffected.
  - A frame end while the FSM is not IDLE: the new sum is dropped, the old division completes, overrun_o sets.
- Simultaneous events: a COMMIT in the same cycle as a stage-4 compare uses the pre-commit mean (registered value).

Test Plan:
1. Reset, then release with no input -> done_o=ci_o=progress_done_o=overrun_o=0, mean_o=MEAN_INIT, all for 20 cycles.
2. IMG_W=IMG_H=4, MEAN_INIT=40, one window 90,10,50,30,70,20,80,40,60 -> done_o exactly 4 cycles later with ci_o=1 (med 50); repeat with all samples 39 -> ci_o=0.
3. Same config, 16 back-to-back constant windows of value 10,20,...,160 -> progress_done_o pulses with the 16th done_o. mean_valid_o pulses SUM_W+1 cycles after the last accumulate, with mean_o=85 (1360/16).
4. Following frame with legal gap, windows of 85 then 84 -> ci_o=1 then 0; wrap-around verified by a third frame all 255 -> mean_o=255.
5. Start the next frame 2 cycles after the last window -> overrun_o=1 and held; early pixels compared against the previous mean; later pixels use the new mean after COMMIT.
6. Assert rst after 7 windows of a frame, then send a full frame of 16 windows of value 8 -> mean_o=8 with no contribution from the aborted pixels. With USE_PREV_MEAN=0 and thr_i=100, window value 100 -> ci_o=1, value 99 -> ci_o=0.
